// File: rtl/ucsbece152a_counter_pkg.sv
// Shared types for the up/down counter sequencer: run modes and controller states.
package ucsbece152a_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_STEP   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } ctrl_state_e;

endpackage

// File: rtl/ucsbece152a_prescaler.sv
// Step pacing divider: counts 0..DIV-1 while run_i, tick_o marks the wrap cycle.
module ucsbece152a_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic run_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick_o = run_i && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cnt <= '0;
    else if (clr_i)  cnt <= '0;
    else if (run_i)  cnt <= tick_o ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/ucsbece152a_counter_ctrl.sv
// Sequencer for the up/down counter: run/hold/idle FSM, bounce reversal,
// wrap detection and single-step edge detect; all outputs registered.
module ucsbece152a_counter_ctrl
  import ucsbece152a_counter_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int DIV      = 4,
  parameter int LIMIT_LO = 0,
  parameter int LIMIT_HI = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             hold_i,
  input  logic [1:0]       mode_i,
  input  logic             step_i,
  input  logic             dir_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             enable_o,
  output logic             dir_o,
  output logic             busy_o,
  output logic             turn_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] HI    = WIDTH'(LIMIT_HI);
  localparam logic [WIDTH-1:0] HI_M1 = WIDTH'(LIMIT_HI - 1);
  localparam logic [WIDTH-1:0] LO_P1 = WIDTH'(LIMIT_LO + 1);
  localparam logic [WIDTH-1:0] ONES  = '1;

  ctrl_state_e state, state_n;
  mode_e       mode_q;
  logic        step_q;
  logic        run, tick, clr;
  logic        start_ok, step_fire;
  logic        turn_up, turn_dn, wrap_hit;

  assign start_ok  = (state == IDLE) && !stop_i && start_i && (mode_i != MODE_STEP);
  assign step_fire = (state == IDLE) && !stop_i && (mode_i == MODE_STEP) && step_i && !step_q;

  // Prescaler freezes on the very edge hold_i is sampled, so HOLD never issues a step.
  assign run = (state != IDLE) && !stop_i && !hold_i;
  assign clr = (state == IDLE) || stop_i;

  ucsbece152a_prescaler #(.DIV(DIV)) u_presc (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .run_i  (run),
    .tick_o (tick)
  );

  assign turn_up  = enable_o && (mode_q == MODE_BOUNCE) && !dir_o && (count_i == HI_M1);
  assign turn_dn  = enable_o && (mode_q == MODE_BOUNCE) &&  dir_o && (count_i == LO_P1);
  assign wrap_hit = enable_o && (mode_q != MODE_BOUNCE) &&
                    ((!dir_o && count_i == ONES) || (dir_o && count_i == '0));

  always_comb begin
    state_n = state;
    if (stop_i) state_n = IDLE;
    else begin
      case (state)
        IDLE:    if (start_ok) state_n = RUN;
        RUN:     if (hold_i)   state_n = HOLD;
        HOLD:    if (!hold_i)  state_n = RUN;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      mode_q   <= MODE_UP;
      step_q   <= 1'b0;
      enable_o <= 1'b0;
      dir_o    <= 1'b0;
      busy_o   <= 1'b0;
      turn_o   <= 1'b0;
      wrap_o   <= 1'b0;
    end else begin
      state    <= state_n;
      step_q   <= step_i;
      enable_o <= tick || step_fire;
      busy_o   <= (state_n != IDLE);
      turn_o   <= turn_up || turn_dn;
      wrap_o   <= wrap_hit;
      if (start_ok) begin
        mode_q <= mode_e'(mode_i);
        case (mode_e'(mode_i))
          MODE_DOWN:   dir_o <= 1'b1;
          MODE_BOUNCE: dir_o <= (count_i >= HI);
          default:     dir_o <= 1'b0;
        endcase
      end else if (step_fire) begin
        // Single steps always qualify for wrap, whatever the last run mode was.
        mode_q <= MODE_STEP;
        dir_o  <= dir_i;
      end else if (turn_up) begin
        dir_o <= 1'b1;
      end else if (turn_dn) begin
        dir_o <= 1'b0;
      end
    end
  end

endmodule
